apb2axi_bridge: RTL and testbench



---
 rtl/apb2axi_pkg.sv | 29 ++
 rtl/apb2axi_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_apb2axi_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb2axi_pkg
//  Purpose  : Shared types and AXI encodings for the APB3-to-AXI4 bridge.
//  Revision : 1.0  initial release
// ============================================================================
package apb2axi_pkg;

  // Bridge sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_READ    = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } apb2axi_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

endpackage
`default_nettype wire

// File: rtl/apb2axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb2axi_bridge
//  Purpose  : APB3 slave to AXI4 master bridge; each APB transfer becomes one
//             single-beat AXI access, pready is held low until the response.
//  Revision : 1.0  initial release
// ============================================================================
module apb2axi_bridge
  import apb2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // APB3 slave
  input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
  input  logic [31:0]                 pwdata_i,
  input  logic                        pwrite_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  output logic [31:0]                 prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  // AXI4 write address
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_cache_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_qos_o,
  output logic [3:0]                  aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  // AXI4 write data
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic [AXI_USER_WIDTH-1:0]   w_user_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  // AXI4 write response
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  input  logic [AXI_USER_WIDTH-1:0]   b_user_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  // AXI4 read address
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_cache_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_qos_o,
  output logic [3:0]                  ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]   ar_user_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  // AXI4 read data
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   r_user_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  // Parameter legality is checked at elaboration
  if ((AXI_DATA_WIDTH != 32) && (AXI_DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("apb2axi_bridge: AXI_DATA_WIDTH must be 32 or 64");
  end
  if (APB_ADDR_WIDTH > AXI_ADDR_WIDTH) begin : g_bad_addr_width
    $error("apb2axi_bridge: APB_ADDR_WIDTH must not exceed AXI_ADDR_WIDTH");
  end

  apb2axi_state_e              state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]                 wdata_q;
  logic                        hi_lane_q;
  logic                        aw_valid_q, w_valid_q, aw_done_q, w_done_q;
  logic                        b_ready_q, ar_valid_q, r_ready_q;
  logic                        pready_q, pslverr_q;
  logic [31:0]                 prdata_q;

  logic [AXI_ADDR_WIDTH-1:0]   addr_ext;
  logic                        aw_hs, w_hs;
  logic [31:0]                 rd_lane;

  // Word-aligned AXI address: zero-extend, then clear the byte offset
  assign addr_ext = AXI_ADDR_WIDTH'(paddr_i) & ~AXI_ADDR_WIDTH'(3);
  assign aw_hs    = aw_valid_q & aw_ready_i;
  assign w_hs     = w_valid_q & w_ready_i;

  // Lane placement: 64-bit bus replicates write data and picks the half by addr[2]
  if (AXI_DATA_WIDTH == 64) begin : g_dw64
    assign w_data_o = {wdata_q, wdata_q};
    assign w_strb_o = hi_lane_q ? 8'hF0 : 8'h0F;
    assign rd_lane  = hi_lane_q ? r_data_i[63:32] : r_data_i[31:0];
  end else begin : g_dw32
    assign w_data_o = wdata_q;
    assign w_strb_o = '1;
    assign rd_lane  = r_data_i[31:0];
  end

  // Single-transfer sequencer: APB capture, AXI handshakes, one-cycle completion
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      hi_lane_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      // Completion flags live only for the single DONE cycle
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (psel_i) begin
            addr_q    <= addr_ext;
            wdata_q   <= pwdata_i;
            hi_lane_q <= paddr_i[2];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (pwrite_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= ST_WRITE;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          // AW and W may finish in either order; wait for both before B
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            b_ready_q <= 1'b1;
            state_q   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (b_valid_i) begin
            b_ready_q <= 1'b0;
            pslverr_q <= b_resp_i[1];
            pready_q  <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_READ: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (r_valid_i) begin
            r_ready_q <= 1'b0;
            prdata_q  <= rd_lane;
            pslverr_q <= r_resp_i[1];
            pready_q  <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;

  assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign aw_addr_o   = addr_q;
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = AXI_SIZE_4B;
  assign aw_burst_o  = AXI_BURST_INCR;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = 3'd0;
  assign aw_qos_o    = 4'd0;
  assign aw_region_o = 4'd0;
  assign aw_user_o   = '0;
  assign aw_valid_o  = aw_valid_q;

  assign w_last_o    = 1'b1;
  assign w_user_o    = '0;
  assign w_valid_o   = w_valid_q;
  assign b_ready_o   = b_ready_q;

  assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign ar_addr_o   = addr_q;
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = AXI_SIZE_4B;
  assign ar_burst_o  = AXI_BURST_INCR;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = 3'd0;
  assign ar_qos_o    = 4'd0;
  assign ar_region_o = 4'd0;
  assign ar_user_o   = '0;
  assign ar_valid_o  = ar_valid_q;
  assign r_ready_o   = r_ready_q;

  // Inputs the bridge deliberately ignores (single ID, single beat, no user)
  logic unused_ok;
  assign unused_ok = ^{penable_i, b_id_i, b_resp_i[0], b_user_i, r_id_i,
                       r_resp_i[0], r_last_i, r_user_i, hi_lane_q};

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb2axi_bridge
//  Purpose  : Self-checking bench; a 32-bit and a 64-bit bridge share one AXI
//             slave model, expectations come from a word-addressed memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb2axi_bridge;
  import apb2axi_pkg::*;

  localparam logic [40:0] AX_FIX = {6'd0, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR,
                                    1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // APB drive (shared; each DUT has its own psel)
  logic [31:0] paddr, pwdata;
  logic pwrite, penable, psel32, psel64, sel64;

  // Slave-side drive (shared)
  logic aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [63:0] r_data;

  // 32-bit DUT outputs
  logic [31:0] d32_prdata; logic d32_pready, d32_pslverr;
  logic [5:0] d32_aw_id, d32_aw_user, d32_ar_id, d32_ar_user, d32_w_user;
  logic [31:0] d32_aw_addr, d32_ar_addr, d32_w_data;
  logic [7:0] d32_aw_len, d32_ar_len; logic [2:0] d32_aw_size, d32_ar_size, d32_aw_prot, d32_ar_prot;
  logic [1:0] d32_aw_burst, d32_ar_burst; logic d32_aw_lock, d32_ar_lock;
  logic [3:0] d32_aw_cache, d32_ar_cache, d32_aw_qos, d32_ar_qos, d32_aw_region, d32_ar_region;
  logic [3:0] d32_w_strb;
  logic d32_aw_valid, d32_w_valid, d32_w_last, d32_b_ready, d32_ar_valid, d32_r_ready;

  // 64-bit DUT outputs
  logic [31:0] d64_prdata; logic d64_pready, d64_pslverr;
  logic [5:0] d64_aw_id, d64_aw_user, d64_ar_id, d64_ar_user, d64_w_user;
  logic [31:0] d64_aw_addr, d64_ar_addr; logic [63:0] d64_w_data;
  logic [7:0] d64_aw_len, d64_ar_len; logic [2:0] d64_aw_size, d64_ar_size, d64_aw_prot, d64_ar_prot;
  logic [1:0] d64_aw_burst, d64_ar_burst; logic d64_aw_lock, d64_ar_lock;
  logic [3:0] d64_aw_cache, d64_ar_cache, d64_aw_qos, d64_ar_qos, d64_aw_region, d64_ar_region;
  logic [7:0] d64_w_strb;
  logic d64_aw_valid, d64_w_valid, d64_w_last, d64_b_ready, d64_ar_valid, d64_r_ready;

  apb2axi_bridge #(.AXI_DATA_WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel32), .penable_i(penable),
    .prdata_o(d32_prdata), .pready_o(d32_pready), .pslverr_o(d32_pslverr),
    .aw_id_o(d32_aw_id), .aw_addr_o(d32_aw_addr), .aw_len_o(d32_aw_len), .aw_size_o(d32_aw_size),
    .aw_burst_o(d32_aw_burst), .aw_lock_o(d32_aw_lock), .aw_cache_o(d32_aw_cache), .aw_prot_o(d32_aw_prot),
    .aw_qos_o(d32_aw_qos), .aw_region_o(d32_aw_region), .aw_user_o(d32_aw_user),
    .aw_valid_o(d32_aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(d32_w_data), .w_strb_o(d32_w_strb), .w_last_o(d32_w_last), .w_user_o(d32_w_user),
    .w_valid_o(d32_w_valid), .w_ready_i(w_ready),
    .b_id_i(6'd0), .b_resp_i(b_resp), .b_user_i(6'd0), .b_valid_i(b_valid), .b_ready_o(d32_b_ready),
    .ar_id_o(d32_ar_id), .ar_addr_o(d32_ar_addr), .ar_len_o(d32_ar_len), .ar_size_o(d32_ar_size),
    .ar_burst_o(d32_ar_burst), .ar_lock_o(d32_ar_lock), .ar_cache_o(d32_ar_cache), .ar_prot_o(d32_ar_prot),
    .ar_qos_o(d32_ar_qos), .ar_region_o(d32_ar_region), .ar_user_o(d32_ar_user),
    .ar_valid_o(d32_ar_valid), .ar_ready_i(ar_ready),
    .r_id_i(6'd0), .r_data_i(r_data[31:0]), .r_resp_i(r_resp), .r_last_i(1'b1), .r_user_i(6'd0),
    .r_valid_i(r_valid), .r_ready_o(d32_r_ready)
  );

  apb2axi_bridge #(.AXI_DATA_WIDTH(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel64), .penable_i(penable),
    .prdata_o(d64_prdata), .pready_o(d64_pready), .pslverr_o(d64_pslverr),
    .aw_id_o(d64_aw_id), .aw_addr_o(d64_aw_addr), .aw_len_o(d64_aw_len), .aw_size_o(d64_aw_size),
    .aw_burst_o(d64_aw_burst), .aw_lock_o(d64_aw_lock), .aw_cache_o(d64_aw_cache), .aw_prot_o(d64_aw_prot),
    .aw_qos_o(d64_aw_qos), .aw_region_o(d64_aw_region), .aw_user_o(d64_aw_user),
    .aw_valid_o(d64_aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(d64_w_data), .w_strb_o(d64_w_strb), .w_last_o(d64_w_last), .w_user_o(d64_w_user),
    .w_valid_o(d64_w_valid), .w_ready_i(w_ready),
    .b_id_i(6'd0), .b_resp_i(b_resp), .b_user_i(6'd0), .b_valid_i(b_valid), .b_ready_o(d64_b_ready),
    .ar_id_o(d64_ar_id), .ar_addr_o(d64_ar_addr), .ar_len_o(d64_ar_len), .ar_size_o(d64_ar_size),
    .ar_burst_o(d64_ar_burst), .ar_lock_o(d64_ar_lock), .ar_cache_o(d64_ar_cache), .ar_prot_o(d64_ar_prot),
    .ar_qos_o(d64_ar_qos), .ar_region_o(d64_ar_region), .ar_user_o(d64_ar_user),
    .ar_valid_o(d64_ar_valid), .ar_ready_i(ar_ready),
    .r_id_i(6'd0), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(1'b1), .r_user_i(6'd0),
    .r_valid_i(r_valid), .r_ready_o(d64_r_ready)
  );

  // View of whichever DUT is currently active
  logic s_aw_valid, s_w_valid, s_w_last, s_b_ready, s_ar_valid, s_r_ready, s_pready, s_pslverr;
  logic [31:0] s_aw_addr, s_ar_addr, s_prdata;
  logic [63:0] s_w_data; logic [7:0] s_w_strb; logic [40:0] s_aw_fix, s_ar_fix;
  always_comb begin
    if (sel64) begin
      s_aw_valid = d64_aw_valid; s_w_valid = d64_w_valid; s_w_last = d64_w_last;
      s_b_ready = d64_b_ready; s_ar_valid = d64_ar_valid; s_r_ready = d64_r_ready;
      s_pready = d64_pready; s_pslverr = d64_pslverr; s_prdata = d64_prdata;
      s_aw_addr = d64_aw_addr; s_ar_addr = d64_ar_addr; s_w_data = d64_w_data; s_w_strb = d64_w_strb;
      s_aw_fix = {d64_aw_id, d64_aw_len, d64_aw_size, d64_aw_burst, d64_aw_lock, d64_aw_cache,
                  d64_aw_prot, d64_aw_qos, d64_aw_region, d64_aw_user};
      s_ar_fix = {d64_ar_id, d64_ar_len, d64_ar_size, d64_ar_burst, d64_ar_lock, d64_ar_cache,
                  d64_ar_prot, d64_ar_qos, d64_ar_region, d64_ar_user};
    end else begin
      s_aw_valid = d32_aw_valid; s_w_valid = d32_w_valid; s_w_last = d32_w_last;
      s_b_ready = d32_b_ready; s_ar_valid = d32_ar_valid; s_r_ready = d32_r_ready;
      s_pready = d32_pready; s_pslverr = d32_pslverr; s_prdata = d32_prdata;
      s_aw_addr = d32_aw_addr; s_ar_addr = d32_ar_addr;
      s_w_data = {32'd0, d32_w_data}; s_w_strb = {4'd0, d32_w_strb};
      s_aw_fix = {d32_aw_id, d32_aw_len, d32_aw_size, d32_aw_burst, d32_aw_lock, d32_aw_cache,
                  d32_aw_prot, d32_aw_qos, d32_aw_region, d32_aw_user};
      s_ar_fix = {d32_ar_id, d32_ar_len, d32_ar_size, d32_ar_burst, d32_ar_lock, d32_ar_cache,
                  d32_ar_prot, d32_ar_qos, d32_ar_region, d32_ar_user};
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned idx);
    return 32'h5A00_0000 ^ (idx * 32'h0001_0003);
  endfunction

  // ---------------- AXI slave model ----------------
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0] cur_bresp, cur_rresp;
  logic [31:0] slv_mem [int unsigned];
  logic aw_got, w_got, b_pend, r_pend;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int aw_hs_n = 0, w_hs_n = 0, b_early_n = 0;
  logic [31:0] cap_awaddr, cap_araddr;
  logic [63:0] cap_wdata; logic [7:0] cap_wstrb; logic cap_wlast;
  logic [40:0] cap_aw_fix, cap_ar_fix;

  function automatic logic [31:0] slv_rd(input int unsigned idx);
    return slv_mem.exists(idx) ? slv_mem[idx] : init_word(idx);
  endfunction

  // Handshake observation at the clock edge (pre-edge values)
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      if (s_b_ready && !b_pend) b_early_n++;
      if (s_aw_valid && aw_ready) begin
        aw_hs_n++; aw_got = 1'b1; cap_awaddr = s_aw_addr; cap_aw_fix = s_aw_fix;
      end
      if (s_w_valid && w_ready) begin
        w_hs_n++; w_got = 1'b1; cap_wdata = s_w_data; cap_wstrb = s_w_strb; cap_wlast = s_w_last;
      end
      if (s_b_ready && b_valid) b_pend = 1'b0;
      if (aw_got && w_got) begin
        if (sel64) begin
          if (cap_wstrb[3:0] == 4'hF) slv_mem[(cap_awaddr >> 3) << 1] = cap_wdata[31:0];
          if (cap_wstrb[7:4] == 4'hF) slv_mem[((cap_awaddr >> 3) << 1) + 1] = cap_wdata[63:32];
        end else if (cap_wstrb[3:0] == 4'hF) begin
          slv_mem[cap_awaddr >> 2] = cap_wdata[31:0];
        end
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
      end
      if (s_ar_valid && ar_ready) begin
        cap_araddr = s_ar_addr; cap_ar_fix = s_ar_fix; r_pend = 1'b1;
      end else if (s_r_ready && r_valid) begin
        r_pend = 1'b0;
      end
    end
  end

  // Ready/valid generation with configurable wait cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      b_resp = 2'b00; r_resp = 2'b00; r_data = '0;
    end else begin
      if (s_aw_valid) begin aw_ready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin aw_ready = 1'b0; aw_cnt = 0; end
      if (s_w_valid) begin w_ready = (w_cnt >= w_dly); w_cnt++; end
      else begin w_ready = 1'b0; w_cnt = 0; end
      if (s_ar_valid) begin ar_ready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin ar_ready = 1'b0; ar_cnt = 0; end
      if (b_pend) begin b_valid = (b_cnt >= b_dly); b_cnt++; end
      else begin b_valid = 1'b0; b_cnt = 0; end
      if (r_pend) begin r_valid = (r_cnt >= r_dly); r_cnt++; end
      else begin r_valid = 1'b0; r_cnt = 0; end
      b_resp = cur_bresp;
      r_resp = cur_rresp;
      if (sel64)
        r_data = {slv_rd(((cap_araddr >> 3) << 1) + 1), slv_rd((cap_araddr >> 3) << 1)};
      else
        r_data = {~slv_rd(cap_araddr >> 2), slv_rd(cap_araddr >> 2)};
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int unsigned];
  function automatic logic [31:0] ref_rd(input int unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  // One APB transfer; ad = AW/AR wait, wd = W wait, bd = B/R wait
  task automatic apb_xfer(input bit is64, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int ad, input int wd, input int bd,
                          input logic [1:0] resp, input bit drop_psel);
    int cyc, exp_lat, aw0, w0, be0;
    bit seen;
    logic [31:0] exp_rd;
    sel64 = is64;
    aw_dly = ad; w_dly = wd; ar_dly = ad; b_dly = bd; r_dly = bd;
    cur_bresp = resp; cur_rresp = resp;
    exp_lat = wr ? (3 + ((ad > wd) ? ad : wd) + bd) : (3 + ad + bd);
    exp_rd = ref_rd(addr >> 2);
    if (wr) ref_mem[addr >> 2] = data;
    aw0 = aw_hs_n; w0 = w_hs_n; be0 = b_early_n;
    paddr = addr; pwdata = data; pwrite = wr; penable = 1'b0;
    if (is64) psel64 = 1'b1; else psel32 = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (drop_psel) begin psel32 = 1'b0; psel64 = 1'b0; penable = 1'b0; end
      else penable = 1'b1;
      if (s_pready) seen = 1'b1;
    end
    check_eq("pready_seen", seen, 1'b1);
    if (seen) begin
      check_eq("latency", cyc, exp_lat);
      check_eq("pslverr", s_pslverr, resp[1]);
      if (wr) begin
        check_eq("aw_addr", cap_awaddr, addr & ~32'h3);
        check_eq("aw_fixed", cap_aw_fix, AX_FIX);
        check_eq("w_data", cap_wdata, is64 ? {data, data} : {32'd0, data});
        check_eq("w_strb", cap_wstrb, is64 ? (addr[2] ? 8'hF0 : 8'h0F) : 8'h0F);
        check_eq("w_last", cap_wlast, 1'b1);
        check_eq("aw_count", aw_hs_n - aw0, 1);
        check_eq("w_count", w_hs_n - w0, 1);
        check_eq("b_ready_early", b_early_n - be0, 0);
      end else begin
        check_eq("ar_addr", cap_araddr, addr & ~32'h3);
        check_eq("ar_fixed", cap_ar_fix, AX_FIX);
        check_eq("prdata", s_prdata, exp_rd);
      end
    end
    psel32 = 1'b0; psel64 = 1'b0; penable = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("pready_pulse", s_pready, 1'b0);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel64 = 1'b0; psel32 = 1'b0; psel64 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    cur_bresp = AXI_RESP_OKAY; cur_rresp = AXI_RESP_OKAY;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst32_ctrl", {d32_aw_valid, d32_w_valid, d32_ar_valid, d32_b_ready,
                            d32_r_ready, d32_pready, d32_pslverr}, 7'd0);
    check_eq("rst32_prdata", d32_prdata, 32'd0);
    check_eq("rst64_ctrl", {d64_aw_valid, d64_w_valid, d64_ar_valid, d64_b_ready,
                            d64_r_ready, d64_pready, d64_pslverr}, 7'd0);
    check_eq("rst64_prdata", d64_prdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    apb_xfer(0, 1, 32'h1A10_0004, 32'hDEAD_BEEF, 0, 0, 0, AXI_RESP_OKAY, 0);
    apb_xfer(0, 1, 32'h1A10_0008, 32'h1234_5678, 0, 0, 0, AXI_RESP_OKAY, 0);
    apb_xfer(0, 0, 32'h1A10_0008, 32'h0, 4, 0, 4, AXI_RESP_OKAY, 0);
    apb_xfer(0, 1, 32'h1A10_0010, 32'h0BAD_F00D, 0, 3, 0, AXI_RESP_OKAY, 0);
    apb_xfer(0, 1, 32'h1A10_0014, 32'h7777_1111, 3, 0, 1, AXI_RESP_OKAY, 0);
    apb_xfer(1, 1, 32'h1A10_000C, 32'hCAFE_F00D, 0, 0, 0, AXI_RESP_OKAY, 0);
    apb_xfer(1, 0, 32'h1A10_000C, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 0);
    apb_xfer(1, 0, 32'h1A10_0008, 32'h0, 1, 0, 2, AXI_RESP_OKAY, 0);
    apb_xfer(0, 0, 32'h1A10_0004, 32'h0, 0, 0, 0, AXI_RESP_SLVERR, 0);
    apb_xfer(0, 1, 32'h1A10_0018, 32'h5555_AAAA, 0, 0, 0, AXI_RESP_DECERR, 0);
    apb_xfer(0, 1, 32'h1A10_001E, 32'h0F0F_0F0F, 1, 2, 1, AXI_RESP_OKAY, 1);
    apb_xfer(1, 0, 32'h1A10_001C, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 1);

    // Reset while waiting for the write response
    sel64 = 1'b0; aw_dly = 0; w_dly = 0; b_dly = 30; cur_bresp = AXI_RESP_OKAY;
    paddr = 32'h1A10_0020; pwdata = 32'hA1B2_C3D4; pwrite = 1'b1; psel32 = 1'b1; penable = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk); penable = 1'b1;
    end
    check_eq("pre_rst_bready", d32_b_ready, 1'b1);
    ref_mem[32'h1A10_0020 >> 2] = 32'hA1B2_C3D4;
    rst_n = 1'b0; psel32 = 1'b0; penable = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("mid_rst_ctrl", {d32_aw_valid, d32_w_valid, d32_ar_valid, d32_b_ready,
                              d32_r_ready, d32_pready, d32_pslverr}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);
    apb_xfer(0, 0, 32'h1A10_0020, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 0);

    // Randomized traffic over a small window so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      logic [1:0] rs;
      a  = 32'h1A10_0000 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      d  = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : AXI_RESP_OKAY;
      apb_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
